// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one backing memory port between the instruction-fetch requester
// (imem) and the load/store requester (dmem).
//
// Arbitration:
//   - dmem has priority over imem.
//   - imem is forced through once dmem has been accepted STARVE_LIMIT times
//     in a row while imem was waiting.
//   - A presented but not-yet-accepted grant is locked until it is accepted.
// Every accepted request pushes a one-bit source tag into a small FIFO.
// Each response from memory pops the FIFO head, and that tag steers the
// response valid back to the requester that issued the request.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-high
//   imem_in   in   fetch request bundle (req + req_valid)
//   imem_out  out  fetch response bundle (res.data, req_ready, res_valid)
//   dmem_in   in   LSU request bundle
//   dmem_out  out  LSU response bundle
//   mem_in    out  request to the backing memory
//   mem_out   in   ready and response from the backing memory
//   busy      out  registered: tag FIFO non-empty
//   spurious  out  registered, sticky: a response arrived with no request
//                  outstanding
// ---------------------------------------------------------------------------

package mem_port_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int FCN_W = 2;
  localparam int TYP_W = 3;

  // Memory function codes
  localparam logic [FCN_W-1:0] M_XRD       = 2'd0;
  localparam logic [FCN_W-1:0] M_XWR       = 2'd1;
  localparam logic [FCN_W-1:0] M_FLUSH_ALL = 2'd2;

  // Access types
  localparam logic [TYP_W-1:0] MT_X  = 3'd0;
  localparam logic [TYP_W-1:0] MT_B  = 3'd1;
  localparam logic [TYP_W-1:0] MT_H  = 3'd2;
  localparam logic [TYP_W-1:0] MT_W  = 3'd3;
  localparam logic [TYP_W-1:0] MT_D  = 3'd4;
  localparam logic [TYP_W-1:0] MT_BU = 3'd5;
  localparam logic [TYP_W-1:0] MT_HU = 3'd6;
  localparam logic [TYP_W-1:0] MT_WU = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [FCN_W-1:0] fcn;
    logic [TYP_W-1:0] typ;
  } mem_req_t;                       // 69 bits

  typedef struct packed {
    mem_req_t req;
    logic     req_valid;
  } memory_in_t;                     // 70 bits

  typedef struct packed {
    logic [XLEN-1:0] data;
  } mem_res_t;                       // 32 bits

  typedef struct packed {
    mem_res_t res;
    logic     req_ready;
    logic     res_valid;
  } memory_out_t;                    // 34 bits

endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  memory_in_t  imem_in,
  output memory_out_t imem_out,
  input  memory_in_t  dmem_in,
  output memory_out_t dmem_out,
  output memory_in_t  mem_in,
  input  memory_out_t mem_out,
  output logic        busy,
  output logic        spurious
);

  localparam int CNT_W    = $clog2(OUTSTANDING + 1);
  localparam int PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0]    LAST_PTR   = PTR_W'(OUTSTANDING - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_t;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  arb_state_t          state_reg, state_next;
  src_t                lock_src_reg, lock_src_next;
  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic                busy_reg, busy_next;
  logic                spurious_reg, spurious_next;
  logic                tag_reg [0:OUTSTANDING-1];

  // -------------------------------------------------------------------------
  // Combinational nets
  // -------------------------------------------------------------------------
  logic       full;
  logic       empty;
  logic       imem_elig;
  logic       dmem_elig;
  logic       grant_valid;
  src_t       grant_src;
  memory_in_t sel_in;
  logic       req_valid_out;
  logic       accept;
  logic       push;
  logic       push_tag;
  logic       pop;
  logic       head_tag;

  // The count is compared against its pre-edge value only. A pop in the
  // same cycle never opens a slot for a push, which keeps ready off the
  // response path.
  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  assign imem_elig = imem_in.req_valid && !full;
  assign dmem_elig = dmem_in.req_valid && !full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Arbiter FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ARB_OPEN;
      lock_src_reg <= SRC_IMEM;
    end else begin
      state_reg    <= state_next;
      lock_src_reg <= lock_src_next;
    end
  end

  // -------------------------------------------------------------------------
  // Arbiter FSM: grant selection, request mux, next state
  // -------------------------------------------------------------------------
  always_comb begin
    grant_valid   = 1'b0;
    grant_src     = SRC_IMEM;
    state_next    = state_reg;
    lock_src_next = lock_src_reg;

    if (state_reg == ARB_LOCKED) begin
      // A presented request stays on the port until the memory takes it.
      grant_valid = 1'b1;
      grant_src   = lock_src_reg;
    end else if (imem_elig && (starve_reg == STARVE_MAX)) begin
      grant_valid = 1'b1;
      grant_src   = SRC_IMEM;
    end else if (dmem_elig) begin
      grant_valid = 1'b1;
      grant_src   = SRC_DMEM;
    end else if (imem_elig) begin
      grant_valid = 1'b1;
      grant_src   = SRC_IMEM;
    end

    sel_in        = (grant_src == SRC_DMEM) ? dmem_in : imem_in;
    req_valid_out = grant_valid && sel_in.req_valid;
    accept        = req_valid_out && mem_out.req_ready && !full;

    // Lock while a presented request waits for ready. Release on accept,
    // or if the requester withdraws its valid.
    if (req_valid_out && !accept) begin
      state_next    = ARB_LOCKED;
      lock_src_next = grant_src;
    end else begin
      state_next    = ARB_OPEN;
    end
  end

  // -------------------------------------------------------------------------
  // Request path and ready steering
  // -------------------------------------------------------------------------
  always_comb begin
    mem_in.req       = sel_in.req;
    mem_in.req_valid = req_valid_out;
  end

  // -------------------------------------------------------------------------
  // Response path: route valid by the head tag, broadcast data to both
  // -------------------------------------------------------------------------
  assign pop      = mem_out.res_valid && !empty;
  assign head_tag = tag_reg[rd_ptr_reg];

  always_comb begin
    imem_out           = '0;
    dmem_out           = '0;
    imem_out.res.data  = mem_out.res.data;
    dmem_out.res.data  = mem_out.res.data;
    imem_out.req_ready = grant_valid && (grant_src == SRC_IMEM) &&
                         mem_out.req_ready && !full;
    dmem_out.req_ready = grant_valid && (grant_src == SRC_DMEM) &&
                         mem_out.req_ready && !full;
    imem_out.res_valid = pop && (head_tag == SRC_IMEM);
    dmem_out.res_valid = pop && (head_tag == SRC_DMEM);
  end

  // -------------------------------------------------------------------------
  // Starvation counter
  // -------------------------------------------------------------------------
  always_comb begin
    starve_next = starve_reg;
    if (!imem_in.req_valid || (accept && (grant_src == SRC_IMEM))) begin
      starve_next = '0;
    end else if (accept && (grant_src == SRC_DMEM) &&
                 (starve_reg != STARVE_MAX)) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Tag FIFO control
  // -------------------------------------------------------------------------
  assign push     = accept;
  assign push_tag = (grant_src == SRC_DMEM);

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end

    busy_next     = (count_next != '0);
    // A response with nothing outstanding is dropped and flagged. The FIFO
    // is left alone.
    spurious_next = spurious_reg || (mem_out.res_valid && empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_reg   <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      busy_reg     <= 1'b0;
      spurious_reg <= 1'b0;
    end else begin
      starve_reg   <= starve_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      busy_reg     <= busy_next;
      spurious_reg <= spurious_next;
    end
  end

  // One flop per tag slot. The head is read combinationally so a response
  // can be routed in the cycle it arrives.
  for (genvar gi = 0; gi < OUTSTANDING; gi++) begin : g_tag
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag_reg[gi] <= 1'b0;
      end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        tag_reg[gi] <= push_tag;
      end
    end
  end

  assign busy     = busy_reg;
  assign spurious = spurious_reg;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single backing memory port between the instruction-fetch requester and the data-memory requester. Requests and responses use the `MemoryIn`/`MemoryOut` bundles from `Bundle`. The block sits between the fetch/LSU stages and the memory/bus interface. It arbitrates with data priority plus starvation protection, holds a grant stable until it is accepted, and returns in-order responses to the requester that issued them, using a source-tag FIFO.

## Interface
Parameters:
- `OUTSTANDING`, 2: maximum accepted-but-unanswered requests (tag FIFO depth, ≥1).
- `STARVE_LIMIT`, 4: consecutive dmem acceptances while imem waits, after which imem is forced (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_in`  in  `MemoryIn` (70)  fetch request: `req` {`addr`, `data`, `fcn`, `typ`} and `req_valid`.
- `imem_out`  out  `MemoryOut` (34)  fetch: `res.data`, `req_ready`, `res_valid`.
- `dmem_in`  in  `MemoryIn` (70)  LSU request.
- `dmem_out`  out  `MemoryOut` (34)  LSU response and ready.
- `mem_in`  out  `MemoryIn` (70)  request to the backing memory.
- `mem_out`  in  `MemoryOut` (34)  ready and response from the backing memory.
- `busy`  out  1  high while the tag FIFO is non-empty.
- `spurious`  out  1  sticky; set when a response arrives with the FIFO empty.

## Operation
**Eligibility**
- A requester is eligible when its `req_valid` = 1 and the FIFO is not full.
- Full means count == `OUTSTANDING`. There is no push bypass on a same-cycle pop.

**Grant selection** (combinational, when the lock is clear)
- If imem is eligible and `starve` == `STARVE_LIMIT`: grant imem.
- Otherwise, if dmem is eligible: grant dmem.
- Otherwise, if imem is eligible: grant imem.
- Otherwise: no grant.

**Lock**
- When a grant is presented and `mem_out.req_ready` = 0, register `lock` = 1 and `lock_src` = the granted source.
- While `lock` = 1, the grant is forced to `lock_src` regardless of priority.
- `lock` clears on acceptance.

**Request path**
- `mem_in.req` = granted source's `req`, passed through unmodified. `M_FLUSH_ALL` and all `typ` values pass unchanged.
- `mem_in.req_valid` = granted source's `req_valid` (0 if no grant).
- Granted requester's `req_ready` = `mem_out.req_ready` AND FIFO not full.
- The non-granted requester's `req_ready` = 0.

**Acceptance and the `starve` counter**
- Acceptance: `mem_in.req_valid` && `mem_out.req_ready` && not full. On acceptance, push the source tag (0 = imem, 1 = dmem).
- `starve` is a saturating counter, width clog2(`STARVE_LIMIT`+1):
  - +1 on dmem acceptance while `imem_in.req_valid` = 1.
  - Reset to 0 on imem acceptance, or whenever `imem_in.req_valid` = 0.

**Response path**
- `mem_out.res_valid` with the FIFO non-empty: pop the head; set `res_valid` = 1 only on the head tag's requester.
- `res.data` is broadcast to both requesters; a requester qualifies it with its own `res_valid`.
- `mem_out.res_valid` with the FIFO empty: drop the response, set `spurious`, and leave the FIFO unchanged.

**FIFO boundary cases**
- Simultaneous push and pop: count is unchanged; pointers wrap modulo `OUTSTANDING`.
- When full, a same-cycle pop does not enable a push. Ready stays 0 that cycle and the request is accepted next cycle.

**Requester obligation**
- A requester must hold `req` stable while `req_valid` = 1 and it is not accepted.
- The arbiter does not check this obligation.

**Reset** (asynchronous, mid-transaction included)
- State: FIFO empty, pointers 0, `starve` = 0, `lock` = 0, `spurious` = 0.
- Outputs: `busy` = 0, `imem_out.res_valid` = `dmem_out.res_valid` = 0.
- Responses to requests accepted before reset are treated as spurious.

## Timing
- Request path is combinational: zero-cycle arbiter latency from `*_in` to `mem_in`, and from `mem_out.req_ready` to `*_out.req_ready`.
- Response routing is combinational from the registered FIFO head: `mem_out.res_valid` to `*_out.res_valid` in the same cycle.
- A push takes effect after the edge. A response in the same cycle as its own acceptance sees the pre-push FIFO; minimum usable memory latency is 1 cycle.
- Sustained throughput: one acceptance per cycle while not full and `mem_out.req_ready` = 1.
- `busy` and `spurious` are registered, valid the cycle after the causing edge.

## Test plan
1. **Contention:** both valid, `req_ready` = 1, 1-cycle memory.
   - Dmem accepted for 4 cycles, then imem forced on the 5th.
   - `starve` returns to 0; responses routed dmem×4 then imem.
2. **Lock hold:** imem alone valid, `req_ready` = 0 for 3 cycles; dmem raises valid on cycle 1.
   - `mem_in` stays on imem; imem is accepted when ready rises.
   - Dmem is accepted the following cycle.
3. **FIFO full:** `OUTSTANDING` = 2, responses withheld.
   - Two acceptances, then `req_ready` outputs = 0 and `busy` = 1.
   - A response at count 2 frees a slot; acceptance occurs the next cycle, not the same cycle.
4. **Ordering:** issue imem A 0x100, dmem load B 0x2000, imem C 0x104; memory answers 0xAAAA, 0xBBBB, 0xCCCC in order.
   - `imem_out.res_valid` on 1st and 3rd responses; `dmem_out.res_valid` on 2nd only.
5. **Spurious:** `mem_out.res_valid` = 1 with the FIFO empty.
   - Both `res_valid` = 0, `spurious` = 1 from the next cycle, FIFO count stays 0.
6. **Reset mid-transaction:** assert `reset` asynchronously with 2 outstanding.
   - Outputs clear immediately; `busy` = 0.
   - A post-reset response sets `spurious`; a new imem request is accepted normally.
